ifetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 33 +++
 rtl/ifetch_if.sv | 32 +++
 rtl/ifetch_inst_queue.sv | 102 ++++++++++
 rtl/ifetch.sv | 132 +++++++++++++
 tb/tb_ifetch.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
// Shared constants and types for the instruction fetch unit:
//   OPCODE_JAL    - major opcode of JAL, used for fetch-time redirect
//   IQ_DEPTH_DEF  - default instruction-queue depth
//   IQ_ENTRY_W    - width of one queue entry {inst, pc, pred}
//   fetch_state_e - IDLE / WAIT request state
//   iq_entry_t    - one instruction-queue entry
//   jal_offset()  - sign-extended J-type immediate of a JAL word
// -----------------------------------------------------------------------------
package ifetch_pkg;

    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
    localparam int         IQ_DEPTH_DEF = 16;
    localparam int         IQ_ENTRY_W   = 65;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no request outstanding
        ST_WAIT = 1'b1    // request outstanding at pc
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    // J-immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} live in inst[31:12].
    function automatic logic [31:0] jal_offset(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// -----------------------------------------------------------------------------
// ifetch_if
// Instruction-side request port between the fetch unit and the memory
// controller.
//   mem_in_flg  fetch request (controller's inst_in_flg)
//   mem_addr    fetch address (controller's inst_addr)
//   ret_flg     one-cycle return pulse (controller's ret_inst_in_flg)
//   ret_inst    returned word, valid only with ret_flg
// Modports: master = fetch unit, slave = memory controller.
// -----------------------------------------------------------------------------
interface ifetch_if;

    logic        mem_in_flg;
    logic [31:0] mem_addr;
    logic        ret_flg;
    logic [31:0] ret_inst;

    modport master (
        output mem_in_flg,
        output mem_addr,
        input  ret_flg,
        input  ret_inst
    );

    modport slave (
        input  mem_in_flg,
        input  mem_addr,
        output ret_flg,
        output ret_inst
    );

endinterface

// File: rtl/ifetch_inst_queue.sv
// -----------------------------------------------------------------------------
// ifetch_inst_queue
// Synchronous FIFO of {inst, pc, pred} entries with push, pop, clear, an
// occupancy count and registered head outputs (no combinational path from
// pop_i to the head outputs).
//   clk, rst      clock, synchronous active-high reset
//   en_i          global enable; low holds every register
//   clr_i         empty the queue (wins over push/pop)
//   push_i        write push_data_i at the tail (never issued when full)
//   push_data_i   entry to write
//   pop_i         consume the head; ignored when empty
//   count_o       occupancy, 0..DEPTH
//   head_valid_o  head entry valid
//   head_o        registered copy of the head entry
// -----------------------------------------------------------------------------
module ifetch_inst_queue
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  iq_entry_t        push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output iq_entry_t        head_o
);

    logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, count_after_pop;
    logic             valid_q, valid_d;
    iq_entry_t        head_ent_q, head_ent_d;
    logic             do_pop;

    always_comb begin
        // NOTE: every combinational output is assigned unconditionally before
        // any branch, so no path can leave it unassigned and infer a latch.
        do_pop          = pop_i && valid_q;
        count_after_pop = count_q - CNT_W'(do_pop);
        head_d          = head_q + PTR_W'(do_pop);
        tail_d          = tail_q + PTR_W'(push_i);
        count_d         = count_after_pop + CNT_W'(push_i);
        valid_d         = (count_d != '0);
        head_ent_d      = head_ent_q;

        if (push_i && (count_after_pop == '0)) begin
            // Queue is (or becomes) empty, so the word being written is the
            // next head; storage is not written until this same edge.
            head_ent_d = push_data_i;
        end else if (count_after_pop != '0) begin
            head_ent_d = iq_entry_t'(mem_q[head_d]);
        end

        if (clr_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            valid_d    = 1'b0;
            head_ent_d = head_ent_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_ent_q <= '0;
        end else if (en_i) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_ent_q <= head_ent_d;
        end
    end

    // NOTE: entry storage has no reset; count/valid gate every read, so
    // stale contents are never presented as a valid head.
    always_ff @(posedge clk) begin
        if (en_i && push_i && !clr_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = valid_q;
    assign head_o       = head_ent_q;

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction fetch unit. Holds the PC, issues one word fetch at a time to
// the memory controller, pushes {inst, pc, pred} into an instruction queue
// the decoder pops, and redirects on a commit-side flush.
//   clk, rst    clock, synchronous active-high reset
//   rdy         global enable; low holds all state
//   flush_flg   redirect from commit; flush_pc is the new PC
//   mem_bus     request/return port to the memory controller (master side)
//   iq_valid    queue head valid; iq_inst / iq_pc / iq_pred head fields
//   iq_pop      decoder consumes the head this cycle
// Build option: define IFU_JAL_PRED_EN to resolve JAL targets at fetch and
// mark those entries pred = 1; otherwise next PC is always pc + 4 and
// iq_pred stays 0.
// -----------------------------------------------------------------------------
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          IQ_DEPTH = IQ_DEPTH_DEF,
    parameter logic [31:0] RST_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush_flg,
    input  logic [31:0] flush_pc,
    ifetch_if.master    mem_bus,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred,
    input  logic        iq_pop
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      next_pc;
    logic             pred;
    logic             iq_push;
    logic             iq_clr;
    logic             iq_has_room;
    logic [CNT_W-1:0] iq_count;
    iq_entry_t        push_entry;
    iq_entry_t        head_entry;

    // Successor of the word returning now.
    always_comb begin
        next_pc = pc_q + 32'd4;
        pred    = 1'b0;
`ifdef IFU_JAL_PRED_EN
        if (mem_bus.ret_inst[6:0] == OPCODE_JAL) begin
            next_pc = pc_q + jal_offset(mem_bus.ret_inst);
            pred    = 1'b1;
        end
`endif
    end

    assign push_entry  = '{inst: mem_bus.ret_inst, pc: pc_q, pred: pred};
    // Room is checked before issue; with one request in flight a push can
    // therefore never meet a full queue.
    assign iq_has_room = (iq_count < CNT_W'(IQ_DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iq_push = 1'b0;
        iq_clr  = 1'b0;

        if (rdy) begin
            if (flush_flg) begin
                // A return in the flush cycle belongs to the squashed path
                // and is dropped; the controller drops its fetch as well.
                iq_clr  = 1'b1;
                pc_d    = flush_pc;
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (iq_has_room) begin
                            state_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_bus.ret_flg) begin
                            iq_push = 1'b1;
                            pc_d    = next_pc;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RST_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Gated by ret_flg so the controller never sees a second request for an
    // address whose word is already returning; not gated by rdy.
    assign mem_bus.mem_in_flg = (state_q == ST_WAIT) && !mem_bus.ret_flg && !flush_flg;
    assign mem_bus.mem_addr   = pc_q;

    ifetch_inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_inst_queue (
        .clk          (clk),
        .rst          (rst),
        .en_i         (rdy),
        .clr_i        (iq_clr),
        .push_i       (iq_push),
        .push_data_i  (push_entry),
        .pop_i        (iq_pop),
        .count_o      (iq_count),
        .head_valid_o (iq_valid),
        .head_o       (head_entry)
    );

    assign iq_inst = head_entry.inst;
    assign iq_pc   = head_entry.pc;
    assign iq_pred = head_entry.pred;

endmodule

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch
// Self-checking bench for ifetch. A memory responder answers fetches with a
// deterministic word per address and appends the expected queue entry to a
// scoreboard; a monitor compares the DUT queue head against the scoreboard
// every cycle and retires entries as the decoder side pops them.
// -----------------------------------------------------------------------------
module tb_ifetch;

    localparam int DEPTH = 16;
`ifdef IFU_JAL_PRED_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush_flg;
    logic [31:0] flush_pc;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred;
    logic        iq_pop;

    ifetch_if mem_bus ();

    ifetch #(
        .IQ_DEPTH (DEPTH),
        .RST_PC   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush_flg (flush_flg),
        .flush_pc  (flush_pc),
        .mem_bus   (mem_bus),
        .iq_valid  (iq_valid),
        .iq_inst   (iq_inst),
        .iq_pc     (iq_pc),
        .iq_pred   (iq_pred),
        .iq_pop    (iq_pop)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [31:0] model_pc  = 32'h0;
    bit          pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          req_cnt   = 0;
    logic [31:0] last_req  = 32'h0;
    bit          jal10     = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // JAL rd=x0 with byte offset off.
    function automatic logic [31:0] jal_word(input int off);
        logic [20:0] imm;
        imm = 21'(off);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    // Memory image: plain ALU words, with JALs sprinkled above 0x200 and an
    // optional JAL +8 planted at 0x10.
    function automatic void word_at(input logic [31:0] a, output logic [31:0] w,
                                    output bit is_jal, output int off);
        logic [31:0] h;
        h      = a * 32'h9E3779B1;
        is_jal = 1'b0;
        off    = 0;
        if (jal10 && a == 32'h10) begin
            is_jal = 1'b1;
            off    = 8;
        end else if (a >= 32'h200 && h[31:29] == 3'b000) begin
            is_jal = 1'b1;
            off    = (int'(h[27:24]) - 8) * 4;
        end
        w = is_jal ? jal_word(off) : {h[31:7], 7'b0010011};
    endfunction

    // Responder drive side: return the word for the outstanding request.
    initial begin
        logic [31:0] w;
        bit          j;
        int          o;
        mem_bus.ret_flg  = 1'b0;
        mem_bus.ret_inst = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            mem_bus.ret_flg = 1'b0;
            if (!rst && pend && rdy) begin
                if (pend_wait > 0) begin
                    pend_wait--;
                end else begin
                    word_at(pend_addr, w, j, o);
                    mem_bus.ret_flg  = 1'b1;
                    mem_bus.ret_inst = w;
                end
            end
        end
    end

    // Responder bookkeeping: reference PC, expected entries, request capture.
    initial begin
        logic [31:0] w;
        bit          j;
        int          o;
        exp_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend     = 1'b0;
                model_pc = 32'h0;
                exp_q.delete();
            end else begin
                if (rdy && flush_flg) begin
                    exp_q.delete();
                    model_pc = flush_pc;
                    pend     = 1'b0;
                end else if (rdy && mem_bus.ret_flg) begin
                    word_at(model_pc, w, j, o);
                    e.inst = w;
                    e.pc   = model_pc;
                    e.pred = JAL_ON && j;
                    exp_q.push_back(e);
                    model_pc = (JAL_ON && j) ? model_pc + 32'(o) : model_pc + 32'd4;
                    pend     = 1'b0;
                end
                if (mem_bus.mem_in_flg && !pend) begin
                    check("request address", mem_bus.mem_addr, model_pc);
                    pend      = 1'b1;
                    pend_addr = mem_bus.mem_addr;
                    pend_wait = $urandom_range(lat_max, lat_min) - 1;
                    req_cnt++;
                    last_req  = mem_bus.mem_addr;
                end
            end
        end
    end

    // Monitor: head must always match the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("iq_valid", iq_valid, exp_q.size() != 0);
                if (iq_valid && exp_q.size() != 0) begin
                    check("head entry", {iq_inst, iq_pc, iq_pred},
                          {exp_q[0].inst, exp_q[0].pc, exp_q[0].pred});
                end
                if (rdy && !flush_flg && iq_pop && iq_valid && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_size(input int n, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == n) ok = 1'b1;
        end
        if (!ok) check({"timeout ", name}, 0, 1);
    endtask

    task automatic wait_req(input int target, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #2;
            if (req_cnt >= target) ok = 1'b1;
        end
        if (!ok) check({"timeout ", name}, 0, 1);
    endtask

    task automatic wait_ret_cycle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #3;
            if (mem_bus.ret_flg) ok = 1'b1;
        end
        if (!ok) check({"timeout ", name}, 0, 1);
    endtask

    task automatic do_flush(input logic [31:0] target);
        @(posedge clk);
        #1;
        flush_flg = 1'b1;
        flush_pc  = target;
        @(posedge clk);
        #1;
        flush_flg = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] saved_addr;
        logic        saved_valid;

        rst       = 1'b1;
        rdy       = 1'b1;
        flush_flg = 1'b0;
        flush_pc  = 32'h0;
        iq_pop    = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_in_flg", mem_bus.mem_in_flg, 0);
        check("reset mem_addr", mem_bus.mem_addr, 32'h0);
        check("reset iq_valid", iq_valid, 0);
        check("reset iq_inst", iq_inst, 32'h0);
        check("reset iq_pc", iq_pc, 32'h0);
        check("reset iq_pred", iq_pred, 0);

        // First issue: IDLE in t, request in t+1 at address 0.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("no request in first idle cycle", mem_bus.mem_in_flg, 0);
        @(negedge clk);
        check("request after idle", mem_bus.mem_in_flg, 1);
        check("first address", mem_bus.mem_addr, 32'h0);

        // Fill without pops: exactly DEPTH pushes, then no more requests.
        wait_size(DEPTH, 300, "fill");
        repeat (8) begin
            @(negedge clk);
            check("no request when full", mem_bus.mem_in_flg, 0);
        end
        n = req_cnt;
        @(posedge clk);
        #1;
        iq_pop = 1'b1;
        @(posedge clk);
        #1;
        iq_pop = 1'b0;
        wait_req(n + 1, 30, "refill request");
        check("refill address", last_req, 32'd64);
        repeat (10) @(negedge clk);
        check("single refill request", req_cnt, n + 1);
        check("full again", mem_bus.mem_in_flg, 0);

        // Drain in order (monitor checks 0, 4, 8, ...).
        @(posedge clk);
        #1;
        iq_pop = 1'b1;
        wait_size(0, 100, "drain");
        @(posedge clk);
        #1;
        iq_pop = 1'b0;

        // Flush in the same cycle as a return.
        wait_ret_cycle("return before flush");
        flush_flg = 1'b1;
        flush_pc  = 32'h100;
        n         = req_cnt;
        @(posedge clk);
        #1;
        flush_flg = 1'b0;
        @(negedge clk);
        check("empty after flush", iq_valid, 0);
        wait_req(n + 1, 30, "request after flush");
        check("address after flush", last_req, 32'h100);

        // JAL +8 at 0x10.
        jal10 = 1'b1;
        n     = req_cnt;
        do_flush(32'h10);
        wait_req(n + 1, 30, "jal fetch");
        check("jal fetch address", last_req, 32'h10);
        wait_req(n + 2, 30, "after jal");
        check("address after jal", last_req, JAL_ON ? 32'h18 : 32'h14);
        @(negedge clk);
        check("jal head pc", iq_pc, 32'h10);
        check("jal head inst", iq_inst, 32'h0080006F);
        check("jal head pred", iq_pred, JAL_ON);

        // rdy low for 5 cycles while a request is outstanding.
        lat_min = 4;
        lat_max = 4;
        n       = req_cnt;
        do_flush(32'h40);
        wait_req(n + 1, 30, "request before stall");
        @(posedge clk);
        #1;
        rdy         = 1'b0;
        saved_addr  = mem_bus.mem_addr;
        saved_valid = iq_valid;
        repeat (5) begin
            @(negedge clk);
            check("stall mem_addr", mem_bus.mem_addr, 32'h40);
            check("stall mem_in_flg", mem_bus.mem_in_flg, 1);
            check("stall iq_valid", iq_valid, saved_valid);
        end
        check("stall addr unchanged", mem_bus.mem_addr, saved_addr);
        @(posedge clk);
        #1;
        rdy     = 1'b1;
        wait_size(3, 100, "resume after stall");
        lat_min = 1;
        lat_max = 1;

        // Push and pop together with one entry queued.
        do_flush(32'h80);
        wait_size(1, 50, "single entry");
        wait_ret_cycle("return with one entry");
        iq_pop = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("push+pop keeps valid", iq_valid, 1);
        check("push+pop head advances", iq_pc, 32'h84);
        @(posedge clk);
        #1;
        iq_pop = 1'b0;
        @(negedge clk);
        check("count was one", iq_valid, 0);

        // Randomised traffic.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rdy       = ($urandom_range(0, 9) != 0);
            iq_pop    = $urandom_range(0, 1) == 1;
            flush_flg = rdy && ($urandom_range(0, 63) == 0);
            flush_pc  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        end
        @(posedge clk);
        #1;
        rdy       = 1'b1;
        flush_flg = 1'b0;
        iq_pop    = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        iq_pop = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
